sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Shares the single synchronous SRAM port between the instruction-fetch requester (IF) and the data requester (EXE load/store path). It grants at most one request per cycle. Data normally has priority, and a starvation counter periodically forces an instruction grant. Completions return in order, RD_LAT cycles after each grant, and are routed back to the owning requester through a tag shift register. The block sits between the pipeline stages and the shared memory in the CPU top.

## Interface
- RD_LAT, 1, SRAM read latency in cycles (legal 1..4); also the latency of every completion.
- STARVE_LIMIT, 3, number of consecutive data grants allowed while inst_req waits (legal 1..15).
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  reset; synchronous and active-low.
- inst_req  in  1  IF request; held with inst_addr until inst_addr_ok.
- inst_addr  in  32  fetch address.
- inst_addr_ok  out  1  IF request granted this cycle.
- inst_data_ok  out  1  IF completion; inst_rdata is valid this cycle.
- inst_rdata  out  32  fetch data.
- data_req  in  1  EXE request; held with its payload until data_addr_ok.
- data_we  in  4  byte write enables; 0 means a read.
- data_addr  in  32  data address.
- data_wdata  in  32  store data, already byte-replicated.
- data_addr_ok  out  1  EXE request granted this cycle.
- data_data_ok  out  1  EXE completion; issued for both reads and writes.
- data_rdata  out  32  load data.
- sram_en  out  1  SRAM access enable.
- sram_we  out  4  SRAM byte write enables.
- sram_addr  out  32  SRAM address.
- sram_wdata  out  32  SRAM write data.
- sram_rdata  in  32  SRAM read data, valid RD_LAT cycles after sram_en.

## Operation
- Grant is combinational each cycle and is forced to none while resetn=0:
  - force_i = inst_req & (starve_cnt == STARVE_LIMIT).
  - Grant data if data_req & ~force_i.
  - Otherwise grant inst if inst_req.
  - Otherwise no grant.
- inst_addr_ok and data_addr_ok are the one-hot grant. Both are never high in the same cycle.
- SRAM drive:
  - Data grant: sram_en=1, sram_we=data_we, sram_addr=data_addr, sram_wdata=data_wdata.
  - Inst grant: sram_en=1, sram_we=0, sram_addr=inst_addr, sram_wdata=0.
  - No grant: all SRAM outputs are 0.
- starve_cnt (4 bits):
  - Increments, saturating at STARVE_LIMIT, when inst_req=1 and data is granted.
  - Clears when inst is granted or when inst_req=0.
  - Holds otherwise.
- Tag pipeline: RD_LAT stages, each holding {vld, owner}.
  - Stage 0 loads {grant_any, grant_is_data}.
  - The stages shift every cycle; there is no stall, because requesters must always accept completions.
- Completion at the last stage:
  - inst_data_ok = vld & ~owner.
  - data_data_ok = vld & owner.
- inst_rdata and data_rdata both equal sram_rdata combinationally. They are meaningful only when the matching data_ok is high.
- Requests complete strictly in grant order. Throughput is one grant per cycle.

## Timing
- Reset values: all tag stages invalid and starve_cnt=0. Every output is 0 while resetn=0, and data_ok stays 0 until RD_LAT cycles after the first grant.
- Grant to data_ok latency is exactly RD_LAT cycles.
- Reset mid-operation: in-flight completions are dropped and are not replayed. No data_ok may appear after resetn rises unless it belongs to a new grant.
- Simultaneous requests with starve_cnt < STARVE_LIMIT: data wins.
- Simultaneous requests with starve_cnt == STARVE_LIMIT: inst wins, and the counter clears on the next edge.
- If inst_req drops while waiting, the counter clears. Requester withdrawal before addr_ok is therefore legal.
- A request and a completion for the same requester in the same cycle are independent and both are legal.
- A data grant with we≠0 still produces data_data_ok RD_LAT cycles later, so the MEM stage can retire the store.

## Structure
- The shared package `mem_if_pkg` holds:
  - Owner encoding: OWNER_INST=0, OWNER_DATA=1.
  - The tag struct {vld, owner}.
  - The RD_LAT and STARVE_LIMIT bound constants, used by elaboration-time assertions.
- Sub-module `arb_tag_pipe` is the parameterised RD_LAT-deep shift register with synchronous active-low clear. The grant logic and starve counter stay in the top.

## Test plan
- IF-only fetch, RD_LAT=1, inst_addr=0x1C000000 → inst_addr_ok=1 and sram_en=1 with addr 0x1C000000 in the same cycle; next cycle inst_data_ok=1 and inst_rdata=sram_rdata. data_data_ok stays 0.
- Both requesters held high for 8 cycles, STARVE_LIMIT=3 → grant sequence D,D,D,I,D,D,D,I. starve_cnt reads 0,1,2,3,0,1,2,3.
- Store with data_we=4'b0011, addr 0x100, wdata 0x0000BEEF → sram_we=0011 and sram_wdata=0x0000BEEF. data_data_ok pulses once, RD_LAT cycles later. No inst_data_ok.
- RD_LAT=3 with alternating I,D,I,D grants → completions I,D,I,D, each exactly 3 cycles after its grant, with correct rdata routing.
- resetn pulled low for 1 cycle with 2 completions in flight → no data_ok for those requests, and starve_cnt=0 after release.
- inst_req dropped while starve_cnt=2 with data_req continuous → counter clears. inst_req re-asserted → inst is granted only after 3 more data grants.

Source files
------------

// File: rtl/mem_if_pkg.sv
// -----------------------------------------------------------------------------
// mem_if_pkg
// Shared definitions for the SRAM port arbiter:
//   - owner_e       : which requester a completion belongs to (IF or EXE data)
//   - tag_t         : one tag-pipeline stage {vld, owner}
//   - bound consts  : legal ranges for RD_LAT and STARVE_LIMIT, checked at
//                     elaboration by the arbiter
// -----------------------------------------------------------------------------
package mem_if_pkg;

   typedef enum logic {
      OWNER_INST = 1'b0,
      OWNER_DATA = 1'b1
   } owner_e;

   typedef struct packed {
      logic   vld;
      owner_e owner;
   } tag_t;

   localparam int RD_LAT_MIN       = 1;
   localparam int RD_LAT_MAX       = 4;
   localparam int STARVE_LIMIT_MIN = 1;
   localparam int STARVE_LIMIT_MAX = 15;
   localparam int STARVE_CNT_W     = 4;

endpackage

// File: rtl/arb_tag_pipe.sv
// -----------------------------------------------------------------------------
// arb_tag_pipe
// DEPTH-stage shift register of completion tags. A tag enters every cycle and
// leaves DEPTH cycles later; there is no stall.
// Ports:
//   clk      in   clock
//   i_clr_n  in   synchronous active-low clear (drops all in-flight tags)
//   i_tag    in   tag for the grant issued this cycle
//   o_tag    out  tag whose completion is due this cycle
// -----------------------------------------------------------------------------
module arb_tag_pipe
   import mem_if_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic clk,
   input  logic i_clr_n,
   input  tag_t i_tag,
   output tag_t o_tag
);

   tag_t [DEPTH-1:0] r_stage;

   // NOTE: sequential state uses non-blocking assignments so every stage reads
   // its predecessor's pre-edge value and the chain shifts by exactly one.
   always_ff @(posedge clk) begin
      if (!i_clr_n) begin
         r_stage <= '0;
      end else begin
         r_stage[0] <= i_tag;
         for (int i = 1; i < DEPTH; i++) begin
            r_stage[i] <= r_stage[i-1];
         end
      end
   end

   assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sram_port_arbiter
// Shares one synchronous SRAM port between instruction fetch (IF) and the
// EXE data path. One grant per cycle, data preferred, with a starvation
// counter that forces an IF grant after STARVE_LIMIT consecutive data grants
// while IF waits. Completions return in order RD_LAT cycles after the grant.
// Ports:
//   clk, resetn                      clock, synchronous active-low reset
//   inst_req/inst_addr               IF request (held until inst_addr_ok)
//   inst_addr_ok/inst_data_ok        IF grant / completion
//   inst_rdata                       IF read data
//   data_req/data_we/data_addr/
//   data_wdata                       EXE request (held until data_addr_ok)
//   data_addr_ok/data_data_ok        EXE grant / completion (reads and writes)
//   data_rdata                       EXE read data
//   sram_en/sram_we/sram_addr/
//   sram_wdata/sram_rdata            shared SRAM port
// -----------------------------------------------------------------------------
module sram_port_arbiter
   import mem_if_pkg::*;
#(
   parameter int RD_LAT       = 1,
   parameter int STARVE_LIMIT = 3
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic [3:0]  data_we,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic        sram_en,
   output logic [3:0]  sram_we,
   output logic [31:0] sram_addr,
   output logic [31:0] sram_wdata,
   input  logic [31:0] sram_rdata
);

   if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
      $error("sram_port_arbiter: RD_LAT out of range");
   end
   if (STARVE_LIMIT < STARVE_LIMIT_MIN || STARVE_LIMIT > STARVE_LIMIT_MAX) begin : g_bad_limit
      $error("sram_port_arbiter: STARVE_LIMIT out of range");
   end

   localparam logic [STARVE_CNT_W-1:0] LP_LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

   logic [STARVE_CNT_W-1:0] r_starve_cnt;
   logic                    w_force_i;
   logic                    w_gnt_data;
   logic                    w_gnt_inst;
   tag_t                    w_tag_in;
   tag_t                    w_tag_out;

   // Grant: data first unless IF has waited out its limit; nothing in reset.
   assign w_force_i  = inst_req & (r_starve_cnt == LP_LIMIT);
   assign w_gnt_data = resetn & data_req & ~w_force_i;
   assign w_gnt_inst = resetn & inst_req & ~w_gnt_data;

   assign inst_addr_ok = w_gnt_inst;
   assign data_addr_ok = w_gnt_data;

   // NOTE: every output of this always_comb gets a default first, so no path
   // leaves a value unassigned and no latch is inferred.
   always_comb begin
      sram_en    = 1'b0;
      sram_we    = '0;
      sram_addr  = '0;
      sram_wdata = '0;
      if (w_gnt_data) begin
         sram_en    = 1'b1;
         sram_we    = data_we;
         sram_addr  = data_addr;
         sram_wdata = data_wdata;
      end else if (w_gnt_inst) begin
         sram_en    = 1'b1;
         sram_addr  = inst_addr;
      end
   end

   // Counts data grants that overtook a waiting IF request; any IF grant or
   // IF withdrawal starts the count over.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_starve_cnt <= '0;
      end else if (!inst_req || w_gnt_inst) begin
         r_starve_cnt <= '0;
      end else if (w_gnt_data && (r_starve_cnt != LP_LIMIT)) begin
         r_starve_cnt <= r_starve_cnt + 1'b1;
      end
   end

   always_comb begin
      w_tag_in.vld   = w_gnt_data | w_gnt_inst;
      w_tag_in.owner = w_gnt_data ? OWNER_DATA : OWNER_INST;
   end

   arb_tag_pipe #(
      .DEPTH (RD_LAT)
   ) u_tag_pipe (
      .clk     (clk),
      .i_clr_n (resetn),
      .i_tag   (w_tag_in),
      .o_tag   (w_tag_out)
   );

   // The pipe only clears on the edge, so the reset cycle itself is masked
   // here to keep every output at 0 while resetn is low.
   assign inst_data_ok = resetn & w_tag_out.vld & (w_tag_out.owner == OWNER_INST);
   assign data_data_ok = resetn & w_tag_out.vld & (w_tag_out.owner == OWNER_DATA);
   assign inst_rdata   = resetn ? sram_rdata : '0;
   assign data_rdata   = resetn ? sram_rdata : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_port_arbiter
// Two arbiters (RD_LAT=1 and RD_LAT=3, STARVE_LIMIT=3) share one stimulus.
// A behavioural model predicts grants, SRAM drive and the completion due in
// each cycle; directed tables and sequences cover the documented corners.
// -----------------------------------------------------------------------------
module tb_sram_port_arbiter;

   localparam int LIMIT = 3;

   logic        clk = 1'b0;
   logic        resetn;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        data_req;
   logic [3:0]  data_we;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;

   logic        i_aok1, i_dok1, d_aok1, d_dok1, en1;
   logic [31:0] i_rd1, d_rd1, addr1, wdata1, srd1;
   logic [3:0]  we1;
   logic        i_aok3, i_dok3, d_aok3, d_dok3, en3;
   logic [31:0] i_rd3, d_rd3, addr3, wdata3, srd3;
   logic [3:0]  we3;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   sram_port_arbiter #(.RD_LAT(1), .STARVE_LIMIT(LIMIT)) u_dut1 (
      .clk(clk), .resetn(resetn),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(i_aok1),
      .inst_data_ok(i_dok1), .inst_rdata(i_rd1),
      .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_addr_ok(d_aok1), .data_data_ok(d_dok1),
      .data_rdata(d_rd1), .sram_en(en1), .sram_we(we1), .sram_addr(addr1),
      .sram_wdata(wdata1), .sram_rdata(srd1)
   );

   sram_port_arbiter #(.RD_LAT(3), .STARVE_LIMIT(LIMIT)) u_dut3 (
      .clk(clk), .resetn(resetn),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(i_aok3),
      .inst_data_ok(i_dok3), .inst_rdata(i_rd3),
      .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_addr_ok(d_aok3), .data_data_ok(d_dok3),
      .data_rdata(d_rd3), .sram_en(en3), .sram_we(we3), .sram_addr(addr3),
      .sram_wdata(wdata3), .sram_rdata(srd3)
   );

   // SRAM model: read data is a fixed function of the address, returned
   // exactly RD_LAT cycles after the access; junk otherwise.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, ~a[31:16]};
   endfunction

   logic        h_en1 = 1'b0;
   logic [31:0] h_addr1 = '0;
   logic        h_en3 [3] = '{1'b0, 1'b0, 1'b0};
   logic [31:0] h_addr3 [3] = '{32'h0, 32'h0, 32'h0};

   always @(posedge clk) begin
      h_en1      <= en1;
      h_addr1    <= addr1;
      h_en3[0]   <= en3;
      h_addr3[0] <= addr3;
      h_en3[1]   <= h_en3[0];
      h_addr3[1] <= h_addr3[0];
      h_en3[2]   <= h_en3[1];
      h_addr3[2] <= h_addr3[1];
   end

   assign srd1 = h_en1    ? mem_word(h_addr1)    : 32'h0BAD_F00D;
   assign srd3 = h_en3[2] ? mem_word(h_addr3[2]) : 32'h0BAD_F00D;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------
   // Reference model, evaluated once per cycle at the falling edge.
   // exp_* is a calendar: slot (cycle % 8) holds the completion due then.
   // ---------------------------------------------------------------------
   int          win = 0;
   int          m_wait = 0;          // data grants that overtook a waiting IF
   logic        exp_v   [2][8];
   logic        exp_own [2][8];      // 1 = data requester
   logic        exp_rd  [2][8];      // 1 = read, rdata is meaningful
   logic [31:0] exp_dat [2][8];
   logic        e_gd, e_gi;
   logic [31:0] e_addr;

   initial begin
      for (int l = 0; l < 2; l++)
         for (int s = 0; s < 8; s++) exp_v[l][s] = 1'b0;
   end

   task automatic check_lane(input int lane, input int lat, input logic iok, input logic dok,
                             input logic [31:0] ird, input logic [31:0] drd);
      int   s  = win % 8;
      int   s2 = (win + lat) % 8;
      logic ev = exp_v[lane][s] && resetn;
      check($sformatf("L%0d inst_data_ok", lat), {31'b0, iok}, {31'b0, ev && !exp_own[lane][s]});
      check($sformatf("L%0d data_data_ok", lat), {31'b0, dok}, {31'b0, ev && exp_own[lane][s]});
      if (ev && exp_rd[lane][s]) begin
         if (exp_own[lane][s]) check($sformatf("L%0d data_rdata", lat), drd, exp_dat[lane][s]);
         else                  check($sformatf("L%0d inst_rdata", lat), ird, exp_dat[lane][s]);
      end
      exp_v[lane][s] = 1'b0;
      if (e_gd || e_gi) begin
         exp_v[lane][s2]   = 1'b1;
         exp_own[lane][s2] = e_gd;
         exp_rd[lane][s2]  = e_gi || (data_we == 4'b0000);
         exp_dat[lane][s2] = mem_word(e_addr);
      end
   endtask

   always @(negedge clk) begin
      logic force_i;
      force_i = inst_req && (m_wait == LIMIT);
      e_gd    = resetn && data_req && !force_i;
      e_gi    = resetn && inst_req && !e_gd;
      e_addr  = e_gd ? data_addr : (e_gi ? inst_addr : 32'h0);

      check("m inst_addr_ok", {31'b0, i_aok3}, {31'b0, e_gi});
      check("m data_addr_ok", {31'b0, d_aok3}, {31'b0, e_gd});
      check("m grant L1 vs model", {30'b0, i_aok1, d_aok1}, {30'b0, e_gi, e_gd});
      check("m sram_en", {31'b0, en3}, {31'b0, e_gd || e_gi});
      check("m sram_we", {28'b0, we3}, {28'b0, e_gd ? data_we : 4'b0000});
      check("m sram_addr", addr3, e_addr);
      check("m sram_wdata", wdata3, e_gd ? data_wdata : 32'h0);
      check("m sram_en L1", {31'b0, en1}, {31'b0, e_gd || e_gi});

      check_lane(0, 1, i_dok1, d_dok1, i_rd1, d_rd1);
      check_lane(1, 3, i_dok3, d_dok3, i_rd3, d_rd3);

      // State as of the coming edge.
      if (!resetn) begin
         m_wait = 0;
         for (int l = 0; l < 2; l++)
            for (int s = 0; s < 8; s++) exp_v[l][s] = 1'b0;
      end else if (!inst_req || e_gi) begin
         m_wait = 0;
      end else if (e_gd && m_wait < LIMIT) begin
         m_wait++;
      end
      win++;
   end

   // ---------------------------------------------------------------------
   // Stimulus helpers
   // ---------------------------------------------------------------------
   task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                        input logic [3:0] we, input logic [31:0] da, input logic [31:0] wd);
      @(posedge clk);
      #1;
      inst_req   = ir;
      inst_addr  = ia;
      data_req   = dr;
      data_we    = we;
      data_addr  = da;
      data_wdata = wd;
   endtask

   task automatic idle();
      drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
   endtask

   typedef struct {
      logic ireq;
      logic dreq;
      logic exp_iok;
      logic exp_dok;
   } vec_t;

   vec_t tbl [15];

   initial begin
      int pulses_d, pulses_i;
      logic g_i, g_d;

      // Both held: D,D,D,I,D,D,D,I. Then IF withdraws at count 2, returns,
      // and has to wait three fresh data grants.
      tbl[0]  = '{1, 1, 0, 1};  tbl[1]  = '{1, 1, 0, 1};  tbl[2]  = '{1, 1, 0, 1};
      tbl[3]  = '{1, 1, 1, 0};  tbl[4]  = '{1, 1, 0, 1};  tbl[5]  = '{1, 1, 0, 1};
      tbl[6]  = '{1, 1, 0, 1};  tbl[7]  = '{1, 1, 1, 0};
      tbl[8]  = '{1, 1, 0, 1};  tbl[9]  = '{1, 1, 0, 1};  tbl[10] = '{0, 1, 0, 1};
      tbl[11] = '{1, 1, 0, 1};  tbl[12] = '{1, 1, 0, 1};  tbl[13] = '{1, 1, 0, 1};
      tbl[14] = '{1, 1, 1, 0};

      resetn = 1'b0;
      inst_req = 1'b1; inst_addr = 32'h1000; data_req = 1'b1;
      data_we = 4'h0; data_addr = 32'h2000; data_wdata = 32'h0;

      // Reset state: requests present but nothing granted or completed.
      @(negedge clk);
      check("reset inst_addr_ok", {31'b0, i_aok1}, 32'h0);
      check("reset data_addr_ok", {31'b0, d_aok1}, 32'h0);
      check("reset sram_en", {31'b0, en1}, 32'h0);
      check("reset sram_addr", addr3, 32'h0);
      check("reset data_ok", {28'b0, i_dok1, d_dok1, i_dok3, d_dok3}, 32'h0);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      inst_req = 1'b0; data_req = 1'b0;

      // IF-only fetch on the RD_LAT=1 arbiter.
      drive(1'b1, 32'h1C00_0000, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge clk);
      check("fetch inst_addr_ok", {31'b0, i_aok1}, 32'h1);
      check("fetch sram_en", {31'b0, en1}, 32'h1);
      check("fetch sram_addr", addr1, 32'h1C00_0000);
      idle();
      @(negedge clk);
      check("fetch inst_data_ok", {31'b0, i_dok1}, 32'h1);
      check("fetch inst_rdata", i_rd1, mem_word(32'h1C00_0000));
      check("fetch rdata passthru", i_rd1, srd1);
      check("fetch data_data_ok", {31'b0, d_dok1}, 32'h0);

      // Starvation table (count is 0 after the idle cycle).
      idle();
      for (int k = 0; k < 15; k++) begin
         drive(tbl[k].ireq, 32'h4000 + 32'(k * 4), tbl[k].dreq, 4'h0,
               32'h8000 + 32'(k * 4), 32'h0);
         @(negedge clk);
         check($sformatf("tbl[%0d] inst_addr_ok", k), {31'b0, i_aok3}, {31'b0, tbl[k].exp_iok});
         check($sformatf("tbl[%0d] data_addr_ok", k), {31'b0, d_aok3}, {31'b0, tbl[k].exp_dok});
      end
      repeat (4) idle();

      // Store: byte enables and data reach the SRAM; one data_ok, 3 later.
      drive(1'b0, 32'h0, 1'b1, 4'b0011, 32'h0000_0100, 32'h0000_BEEF);
      @(negedge clk);
      check("store sram_we", {28'b0, we3}, 32'h3);
      check("store sram_wdata", wdata3, 32'h0000_BEEF);
      check("store sram_addr", addr3, 32'h0000_0100);
      pulses_d = 0; pulses_i = 0;
      for (int k = 0; k < 5; k++) begin
         idle();
         @(negedge clk);
         if (k == 2) check("store data_ok at +3", {31'b0, d_dok3}, 32'h1);
         if (d_dok3) pulses_d++;
         if (i_dok3) pulses_i++;
      end
      check("store data_ok pulses", 32'(pulses_d), 32'h1);
      check("store inst_data_ok pulses", 32'(pulses_i), 32'h0);

      // Alternating I,D,I,D on RD_LAT=3: completions I,D,I,D three later.
      for (int k = 0; k < 7; k++) begin
         if (k < 4) drive(k % 2 == 0, 32'hA000 + 32'(k), k % 2 == 1, 4'h0, 32'hB000 + 32'(k), 32'h0);
         else       idle();
         @(negedge clk);
         if (k >= 3) begin
            check($sformatf("alt[%0d] inst_data_ok", k), {31'b0, i_dok3}, {31'b0, (k - 3) % 2 == 0});
            check($sformatf("alt[%0d] data_data_ok", k), {31'b0, d_dok3}, {31'b0, (k - 3) % 2 == 1});
            if ((k - 3) % 2 == 0) check($sformatf("alt[%0d] inst_rdata", k), i_rd3, mem_word(32'hA000 + 32'(k - 3)));
            else                  check($sformatf("alt[%0d] data_rdata", k), d_rd3, mem_word(32'hB000 + 32'(k - 3)));
         end
      end
      idle();

      // Reset with two completions in flight and the count at 2.
      drive(1'b1, 32'hC000, 1'b1, 4'h0, 32'hD000, 32'h0);
      drive(1'b1, 32'hC000, 1'b1, 4'h0, 32'hD004, 32'h0);
      @(posedge clk);
      #1;
      resetn = 1'b0;
      @(negedge clk);
      check("midrst sram_en", {31'b0, en3}, 32'h0);
      check("midrst data_ok L1", {31'b0, d_dok1}, 32'h0);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) drive(1'b1, 32'hC000, 1'b1, 4'h0, 32'hD008, 32'h0);
         @(negedge clk);
         check($sformatf("postrst[%0d] inst_addr_ok", k), {31'b0, i_aok3}, {31'b0, k == 3});
         if (k < 3) check($sformatf("postrst[%0d] no data_ok", k), {30'b0, i_dok3, d_dok3}, 32'h0);
      end
      check("postrst L1 no stale ok", {31'b0, i_dok1}, 32'h0);
      repeat (4) idle();

      // Randomised traffic, requests held until granted or withdrawn.
      for (int k = 0; k < 600; k++) begin
         @(negedge clk);
         g_i = i_aok3;
         g_d = d_aok3;
         @(posedge clk);
         #1;
         resetn = ($urandom_range(0, 59) != 0);
         if (!inst_req || g_i || $urandom_range(0, 7) == 0) begin
            inst_req  = $urandom_range(0, 1) == 1;
            inst_addr = $urandom;
         end
         if (!data_req || g_d || $urandom_range(0, 7) == 0) begin
            data_req   = $urandom_range(0, 2) != 0;
            data_we    = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            data_addr  = $urandom;
            data_wdata = $urandom;
         end
      end
      resetn = 1'b1;
      repeat (6) idle();
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
